// File: rtl/ipsxe_floating_point_norm_round_v1_0.sv
// Three-stage normalize-and-round for the FMA sum word: leading-one detect,
// normalizing shift with exponent adjust, then round-to-nearest-even and pack.
module ipsxe_floating_point_norm_round_v1_0 #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int W_USER    = 1
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_aclken,
    input  logic                                             i_valid,
    input  logic [(2*(MAN_WIDTH+1)+1)+(EXP_WIDTH+1)+1-1:0]   i_add_in,
    input  logic [W_USER-1:0]                                i_user,
    output logic                                             o_valid,
    output logic [EXP_WIDTH+MAN_WIDTH:0]                     o_result,
    output logic                                             o_overflow,
    output logic                                             o_underflow,
    output logic                                             o_inexact,
    output logic [W_USER-1:0]                                o_user
);

    localparam int MN   = 2*MAN_WIDTH+3;
    localparam int EW   = EXP_WIDTH+1;
    localparam int PW   = $clog2(MN);
    localparam int XW   = EXP_WIDTH+3;
    localparam int SUMW = MAN_WIDTH+2;
    localparam int BIAS = 2**(EXP_WIDTH-1)-1;
    localparam int RW   = 1+EXP_WIDTH+MAN_WIDTH;

    localparam logic signed [XW-1:0] X_MAX = XW'(2**EXP_WIDTH-1);

    logic          in_s;
    logic [EW-1:0] in_e;
    logic [MN-1:0] in_m;

    assign {in_s, in_e, in_m} = i_add_in;

    // ---------------- stage 1: leading-one position ----------------
    logic [PW-1:0] lzc_p;
    logic          lzc_z;

    always_comb begin
        lzc_p = '0;
        for (int unsigned i = 0; i < MN; i++) begin
            if (in_m[i]) lzc_p = PW'(i);
        end
        lzc_z = ~|in_m;
    end

    logic              s1_valid_q;
    logic [W_USER-1:0] s1_user_q;
    logic              s1_s_q;
    logic [EW-1:0]     s1_e_q;
    logic [MN-1:0]     s1_m_q;
    logic [PW-1:0]     s1_p_q;
    logic              s1_z_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_user_q  <= '0;
            s1_s_q     <= 1'b0;
            s1_e_q     <= '0;
            s1_m_q     <= '0;
            s1_p_q     <= '0;
            s1_z_q     <= 1'b0;
        end else if (i_aclken) begin
            s1_valid_q <= i_valid;
            s1_user_q  <= i_user;
            s1_s_q     <= in_s;
            s1_e_q     <= in_e;
            s1_m_q     <= in_m;
            s1_p_q     <= lzc_p;
            s1_z_q     <= lzc_z;
        end
    end

    // ---------------- stage 2: normalize and exponent ----------------
    logic [PW-1:0]        sh_amt;
    logic [MN-1:0]        norm;
    logic [MAN_WIDTH-1:0] s2_frac_d;
    logic                 s2_g_d;
    logic                 s2_t_d;
    logic [XW-1:0]        s2_x_d;

    always_comb begin
        sh_amt    = PW'(MN-1) - s1_p_q;
        norm      = s1_m_q << sh_amt;
        // norm[MN-1] is the hidden bit and is implied from here on
        s2_frac_d = norm[MN-2 -: MAN_WIDTH];
        s2_g_d    = norm[MN-2-MAN_WIDTH];
        s2_t_d    = |norm[MN-3-MAN_WIDTH:0];
        // modular arithmetic in XW bits; the range never reaches the sign wrap
        s2_x_d    = XW'(s1_e_q) + XW'(s1_p_q) - XW'(BIAS + 2*MAN_WIDTH);
    end

    logic                 s2_valid_q;
    logic [W_USER-1:0]    s2_user_q;
    logic                 s2_s_q;
    logic                 s2_z_q;
    logic [MAN_WIDTH-1:0] s2_frac_q;
    logic                 s2_g_q;
    logic                 s2_t_q;
    logic [XW-1:0]        s2_x_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid_q <= 1'b0;
            s2_user_q  <= '0;
            s2_s_q     <= 1'b0;
            s2_z_q     <= 1'b0;
            s2_frac_q  <= '0;
            s2_g_q     <= 1'b0;
            s2_t_q     <= 1'b0;
            s2_x_q     <= '0;
        end else if (i_aclken) begin
            s2_valid_q <= s1_valid_q;
            s2_user_q  <= s1_user_q;
            s2_s_q     <= s1_s_q;
            s2_z_q     <= s1_z_q;
            s2_frac_q  <= s2_frac_d;
            s2_g_q     <= s2_g_d;
            s2_t_q     <= s2_t_d;
            s2_x_q     <= s2_x_d;
        end
    end

    // ---------------- stage 3: round and pack ----------------
    logic                 rnd_inc;
    logic [SUMW-1:0]      rnd_sum;
    logic                 rnd_carry;
    logic [MAN_WIDTH-1:0] rnd_frac;
    logic [XW-1:0]        rnd_x;
    logic                 x_ovf;
    logic                 x_unf;

    logic [RW-1:0]        res_d;
    logic                 ovf_d;
    logic                 unf_d;
    logic                 inx_d;

    always_comb begin
        rnd_inc   = s2_g_q & (s2_t_q | s2_frac_q[0]);
        rnd_sum   = {1'b0, 1'b1, s2_frac_q} + SUMW'(rnd_inc);
        rnd_carry = rnd_sum[SUMW-1];
        rnd_frac  = rnd_carry ? '0 : rnd_sum[MAN_WIDTH-1:0];
        rnd_x     = s2_x_q + XW'(rnd_carry);
        x_ovf     = $signed(rnd_x) >= X_MAX;
        x_unf     = rnd_x[XW-1] | (rnd_x == '0);

        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        if (s2_z_q) begin
            res_d = '0;
        end else if (x_ovf) begin
            res_d = {s2_s_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (x_unf) begin
            res_d = {s2_s_q, {(EXP_WIDTH+MAN_WIDTH){1'b0}}};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end else begin
            res_d = {s2_s_q, rnd_x[EXP_WIDTH-1:0], rnd_frac};
            inx_d = s2_g_q | s2_t_q;
        end
    end

    logic              s3_valid_q;
    logic [W_USER-1:0] s3_user_q;
    logic [RW-1:0]     s3_res_q;
    logic              s3_ovf_q;
    logic              s3_unf_q;
    logic              s3_inx_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s3_valid_q <= 1'b0;
            s3_user_q  <= '0;
            s3_res_q   <= '0;
            s3_ovf_q   <= 1'b0;
            s3_unf_q   <= 1'b0;
            s3_inx_q   <= 1'b0;
        end else if (i_aclken) begin
            s3_valid_q <= s2_valid_q;
            s3_user_q  <= s2_user_q;
            s3_res_q   <= res_d;
            s3_ovf_q   <= ovf_d;
            s3_unf_q   <= unf_d;
            s3_inx_q   <= inx_d;
        end
    end

    assign o_valid     = s3_valid_q;
    assign o_user      = s3_user_q;
    assign o_result    = s3_res_q;
    assign o_overflow  = s3_ovf_q;
    assign o_underflow = s3_unf_q;
    assign o_inexact   = s3_inx_q;

endmodule

// File: tb/tb_ipsxe_floating_point_norm_round_v1_0.sv
// Directed-vector bench for the normalize/round stage (EXP_WIDTH=8, MAN_WIDTH=23).
module tb_ipsxe_floating_point_norm_round_v1_0;

    logic        clk;
    logic        i_rst;
    logic        i_aclken;
    logic        i_valid;
    logic [58:0] i_add_in;
    logic [0:0]  i_user;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_inexact;
    logic [0:0]  o_user;

    int errors = 0;
    int checks = 0;

    ipsxe_floating_point_norm_round_v1_0 #(
        .EXP_WIDTH(8),
        .MAN_WIDTH(23),
        .W_USER(1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_aclken   (i_aclken),
        .i_valid    (i_valid),
        .i_add_in   (i_add_in),
        .i_user     (i_user),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow),
        .o_inexact  (o_inexact),
        .o_user     (o_user)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one word for one clock, then idle; returns outputs 3 clocks later
    // and o_valid as seen after the second clock.
    task automatic run_word(input logic s, input logic [8:0] e, input logic [48:0] m,
                            input logic u, output logic [31:0] res,
                            output logic [3:0] flags, output logic usr, output logic early);
        @(negedge clk);
        i_valid = 1'b1; i_add_in = {s, e, m}; i_user = u;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0; i_add_in = '0; i_user = '0;
        @(posedge clk); #1 early = o_valid;
        @(posedge clk); #1;
        res   = o_result;
        flags = {o_valid, o_overflow, o_underflow, o_inexact};
        usr   = o_user[0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_valid = 1'b0; i_add_in = '0; i_user = '0;
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_aclken = 1'b1; i_valid = 1'b0; i_add_in = '0; i_user = '0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({o_valid, o_overflow, o_underflow, o_inexact, o_user} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {o_valid, o_overflow, o_underflow, o_inexact, o_user});
        end
        checks++;
        if (o_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result got=%h want=00000000", o_result);
        end
        @(negedge clk); i_rst = 1'b0;
        idle(3);
    endtask

    task automatic test_normal;
        logic [48:0] mv [4];
        logic [31:0] ev [4];
        logic        sv [4];
        logic [31:0] r; logic [3:0] f; logic u; logic early;
        mv[0] = 49'd1 << 47;                  sv[0] = 1'b0; ev[0] = 32'h40000000;
        mv[1] = (49'd1 << 46) | (49'd1 << 45); sv[1] = 1'b1; ev[1] = 32'hBFC00000;
        mv[2] = 49'd1 << 20;                  sv[2] = 1'b0; ev[2] = 32'h32800000;
        mv[3] = 49'd1 << 48;                  sv[3] = 1'b0; ev[3] = 32'h40800000;
        for (int k = 0; k < 4; k++) begin
            run_word(sv[k], 9'd254, mv[k], 1'b0, r, f, u, early);
            checks++;
            if (early !== 1'b0) begin
                errors++;
                $display("FAIL normal_latency%0d o_valid_at_2=%b want=0", k, early);
            end
            checks++;
            if (r !== ev[k]) begin
                errors++;
                $display("FAIL normal_result%0d got=%h want=%h", k, r, ev[k]);
            end
            checks++;
            if (f !== 4'b1000 || u !== 1'b0) begin
                errors++;
                $display("FAIL normal_flags%0d got=%b/%b want=1000/0", k, f, u);
            end
        end
    endtask

    task automatic test_rounding;
        logic [48:0] mv [4];
        logic [31:0] ev [4];
        logic [31:0] r; logic [3:0] f; logic u; logic early;
        mv[0] = (49'd1 << 46) | (49'd1 << 22);                  ev[0] = 32'h3F800000;
        mv[1] = (49'd1 << 46) | (49'd1 << 23) | (49'd1 << 22);  ev[1] = 32'h3F800002;
        mv[2] = (49'd1 << 46) | (49'd1 << 22) | 49'd1;          ev[2] = 32'h3F800001;
        mv[3] = (49'd1 << 47) - (49'd1 << 22);                  ev[3] = 32'h40000000;
        for (int k = 0; k < 4; k++) begin
            run_word(1'b0, 9'd254, mv[k], 1'b0, r, f, u, early);
            checks++;
            if (r !== ev[k]) begin
                errors++;
                $display("FAIL round_result%0d got=%h want=%h", k, r, ev[k]);
            end
            checks++;
            if (f !== 4'b1001) begin
                errors++;
                $display("FAIL round_flags%0d got=%b want=1001", k, f);
            end
        end
    endtask

    task automatic test_range;
        logic [8:0]  evv [5];
        logic [48:0] mv  [5];
        logic        sv  [5];
        logic [31:0] rv  [5];
        logic [3:0]  fv  [5];
        logic [31:0] r; logic [3:0] f; logic u; logic early;
        evv[0] = 9'd511; mv[0] = 49'd1 << 46; sv[0] = 1'b1; rv[0] = 32'hFF800000; fv[0] = 4'b1101;
        evv[1] = 9'd127; mv[1] = 49'd1 << 46; sv[1] = 1'b0; rv[1] = 32'h00000000; fv[1] = 4'b1011;
        evv[2] = 9'd381; mv[2] = 49'd1 << 46; sv[2] = 1'b0; rv[2] = 32'h7F000000; fv[2] = 4'b1000;
        evv[3] = 9'd128; mv[3] = 49'd1 << 46; sv[3] = 1'b0; rv[3] = 32'h00800000; fv[3] = 4'b1000;
        evv[4] = 9'd381; mv[4] = (49'd1 << 47) - (49'd1 << 22); sv[4] = 1'b0;
        rv[4] = 32'h7F800000; fv[4] = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            run_word(sv[k], evv[k], mv[k], 1'b0, r, f, u, early);
            checks++;
            if (r !== rv[k]) begin
                errors++;
                $display("FAIL range_result%0d got=%h want=%h", k, r, rv[k]);
            end
            checks++;
            if (f !== fv[k]) begin
                errors++;
                $display("FAIL range_flags%0d got=%b want=%b", k, f, fv[k]);
            end
        end
    endtask

    task automatic test_zero_user;
        logic [31:0] r; logic [3:0] f; logic u; logic early;
        run_word(1'b1, 9'd200, 49'd0, 1'b1, r, f, u, early);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL zero_result got=%h want=00000000", r);
        end
        checks++;
        if (f !== 4'b1000) begin
            errors++;
            $display("FAIL zero_flags got=%b want=1000", f);
        end
        checks++;
        if (u !== 1'b1) begin
            errors++;
            $display("FAIL zero_user got=%b want=1", u);
        end
    endtask

    task automatic test_back_to_back;
        logic [58:0] wv [3];
        logic [31:0] ev [3];
        wv[0] = {1'b0, 9'd254, 49'd1 << 47}; ev[0] = 32'h40000000;
        wv[1] = {1'b1, 9'd254, 49'd1 << 46}; ev[1] = 32'hBF800000;
        wv[2] = {1'b0, 9'd254, 49'd1 << 20}; ev[2] = 32'h32800000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                checks++;
                if (o_valid !== 1'b1 || o_result !== ev[c-3]) begin
                    errors++;
                    $display("FAIL b2b_word%0d got=%b/%h want=1/%h", c-3, o_valid, o_result, ev[c-3]);
                end
            end else if (c >= 6) begin
                checks++;
                if (o_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_tail%0d o_valid=%b want=0", c, o_valid);
                end
            end
            if (c < 3) begin
                i_valid = 1'b1; i_add_in = wv[c];
            end else begin
                i_valid = 1'b0; i_add_in = '0;
            end
        end
        idle(3);
    endtask

    task automatic test_aclken;
        logic [58:0] wv [4];
        logic [31:0] ev [4];
        int          se [4];
        logic        pat [12];
        logic        exp_v;
        logic [31:0] exp_r;
        int          en_cnt;
        int          w;
        wv[0] = {1'b0, 9'd254, 49'd1 << 47}; ev[0] = 32'h40000000;
        wv[1] = {1'b1, 9'd254, 49'd1 << 46}; ev[1] = 32'hBF800000;
        wv[2] = {1'b0, 9'd254, 49'd1 << 20}; ev[2] = 32'h32800000;
        wv[3] = {1'b0, 9'd254, 49'd1 << 48}; ev[3] = 32'h40800000;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_v = 1'b0; exp_r = '0; en_cnt = 0; w = 0;
        for (int k = 0; k < 4; k++) se[k] = -10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++;
                if (o_valid !== exp_v || o_result !== exp_r) begin
                    errors++;
                    $display("FAIL aclken_cyc%0d got=%b/%h want=%b/%h", c, o_valid, o_result, exp_v, exp_r);
                end
            end
            i_aclken = pat[c];
            if (w < 4) begin
                i_valid = 1'b1; i_add_in = wv[w];
            end else begin
                i_valid = 1'b0; i_add_in = '0;
            end
            if (pat[c]) begin
                en_cnt++;
                if (w < 4) begin
                    se[w] = en_cnt;
                    w++;
                end
                exp_v = 1'b0; exp_r = '0;
                for (int k = 0; k < 4; k++) begin
                    if (se[k] + 2 == en_cnt) begin
                        exp_v = 1'b1; exp_r = ev[k];
                    end
                end
            end
        end
        @(negedge clk); i_aclken = 1'b1;
        idle(3);
    endtask

    task automatic test_reset_midstream;
        logic [31:0] r; logic [3:0] f; logic u; logic early;
        @(negedge clk); i_valid = 1'b1; i_add_in = {1'b0, 9'd254, 49'd1 << 47}; i_user = 1'b1;
        @(negedge clk); i_add_in = {1'b1, 9'd511, 49'd1 << 46};
        // reset with enable low: reset must still win
        @(negedge clk); i_valid = 1'b0; i_add_in = '0; i_user = '0; i_rst = 1'b1; i_aclken = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_valid, o_overflow, o_underflow, o_inexact, o_user} !== 5'b0 || o_result !== 32'h0) begin
            errors++;
            $display("FAIL midrst_clear got=%b/%h want=00000/00000000",
                     {o_valid, o_overflow, o_underflow, o_inexact, o_user}, o_result);
        end
        i_rst = 1'b0; i_aclken = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale%0d o_valid=%b want=0", c, o_valid);
            end
        end
        run_word(1'b0, 9'd254, 49'd1 << 47, 1'b0, r, f, u, early);
        checks++;
        if (early !== 1'b0 || r !== 32'h40000000 || f !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_first early=%b got=%h/%b want=0/40000000/1000", early, r, f);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_rounding();
        test_range();
        test_zero_user();
        test_back_to_back();
        test_aclken();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
